choose_ctrl: RTL

CHOOSE_CTRL -- requirements
Module: choose_ctrl

---
 rtl/choose_pkg.sv | 41 ++++
 rtl/frame_blinker.sv | 46 ++++
 rtl/choose_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/choose_pkg.sv
// Shared types and constants for the team-selection scene controller.
// Holds the FSM state, key-action encoding and the cursor stepping helper.
package choose_pkg;

    typedef enum logic {
        BROWSE = 1'b0,
        DONE   = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_BACK  = 3'd1,
        ACT_ENTER = 3'd2,
        ACT_LEFT  = 3'd3,
        ACT_RIGHT = 3'd4,
        ACT_VERT  = 3'd5
    } act_t;

    localparam logic [7:0] POKE_MIN  = 8'd1;
    localparam logic [7:0] POKE_MAX  = 8'd8;
    localparam int         GRID_COLS = 4;
    localparam int         TEAM_SIZE = 3;
    localparam logic [1:0] LAST_SLOT = 2'(TEAM_SIZE - 1);

    // Zero-based index: bit 2 is the row, bits 1:0 the column, so column
    // moves wrap inside the row and a vertical move just flips the row bit.
    function automatic logic [7:0] cursor_step(input logic [7:0] id, input act_t act);
        logic [2:0] idx;
        logic [2:0] nxt;
        idx = 3'(id - POKE_MIN);
        nxt = idx;
        case (act)
            ACT_LEFT:  nxt = {idx[2], idx[1:0] - 2'd1};
            ACT_RIGHT: nxt = {idx[2], idx[1:0] + 2'd1};
            ACT_VERT:  nxt = {~idx[2], idx[1:0]};
            default:   nxt = idx;
        endcase
        return {5'd0, nxt} + POKE_MIN;
    endfunction

endpackage

// File: rtl/frame_blinker.sv
// Cursor blink generator: toggles visibility every BLINK_FRAMES frame ticks.
// A restart pulse shows the cursor immediately and restarts the count.
module frame_blinker #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic restart,
    output logic visible
);

    localparam logic [7:0] LAST_CNT = 8'(BLINK_FRAMES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       vis_q, vis_d;

    always_comb begin
        cnt_d = cnt_q;
        vis_d = vis_q;
        if (restart) begin
            cnt_d = 8'd0;
            vis_d = 1'b1;
        end else if (frame_tick) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = 8'd0;
                vis_d = ~vis_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            vis_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            vis_q <= vis_d;
        end
    end

    assign visible = vis_q;

endmodule

// File: rtl/choose_ctrl.sv
// Choose-scene controller: cursor navigation over a 2x4 grid, team picking
// with duplicate rejection and un-pick, plus the cursor blink phase.
module choose_ctrl
    import choose_pkg::*;
#(
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_enter,
    input  logic       key_back,
    input  logic       frame_tick,
    output logic [7:0] pokemon_id,
    output logic       cursor_visible,
    output logic [7:0] team_0,
    output logic [7:0] team_1,
    output logic [7:0] team_2,
    output logic [1:0] team_cnt,
    output logic       sel_done,
    output logic       err_dup
);

    state_t     state_q, state_d;
    logic [7:0] id_q, id_d;
    logic [7:0] team_q [TEAM_SIZE];
    logic [7:0] team_d [TEAM_SIZE];
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    act_t       act;
    logic       is_dup;
    logic       moved;

    // One action per cycle; lower-priority pulses are simply dropped.
    always_comb begin
        act = ACT_NONE;
        if (en) begin
            if (key_back)               act = ACT_BACK;
            else if (key_enter)         act = ACT_ENTER;
            else if (key_left)          act = ACT_LEFT;
            else if (key_right)         act = ACT_RIGHT;
            else if (key_up || key_down) act = ACT_VERT;
        end
    end

    // Empty slots hold 0, which is never a valid cursor id.
    assign is_dup = (team_q[0] == id_q) || (team_q[1] == id_q) || (team_q[2] == id_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        team_d  = team_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        moved   = 1'b0;
        case (state_q)
            BROWSE: begin
                case (act)
                    ACT_BACK: begin
                        if (cnt_q != 2'd0) begin
                            team_d[cnt_q - 2'd1] = 8'd0;
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                    ACT_ENTER: begin
                        if (is_dup) begin
                            err_d = 1'b1;
                        end else begin
                            team_d[cnt_q] = id_q;
                            cnt_d = cnt_q + 2'd1;
                            if (cnt_q == LAST_SLOT) state_d = DONE;
                        end
                    end
                    ACT_LEFT, ACT_RIGHT, ACT_VERT: begin
                        id_d  = cursor_step(id_q, act);
                        moved = 1'b1;
                    end
                    default: ;
                endcase
            end
            DONE: begin
                if (act == ACT_BACK) begin
                    team_d[LAST_SLOT] = 8'd0;
                    cnt_d   = LAST_SLOT;
                    state_d = BROWSE;
                end
            end
            default: state_d = BROWSE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BROWSE;
            id_q    <= POKE_MIN;
            for (int i = 0; i < TEAM_SIZE; i++) team_q[i] <= 8'd0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            for (int i = 0; i < TEAM_SIZE; i++) team_q[i] <= team_d[i];
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    frame_blinker #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .restart   (moved),
        .visible   (cursor_visible)
    );

    assign pokemon_id = id_q;
    assign team_0     = team_q[0];
    assign team_1     = team_q[1];
    assign team_2     = team_q[2];
    assign team_cnt   = cnt_q;
    assign sel_done   = done_q;
    assign err_dup    = err_q;

endmodule
